// File: rtl/key_debounce_bank.sv
// key_debounce_bank
//   A bank of CH independent key channels. For each channel the raw key level
//   is synchronised, debounced, edge-detected and tracked by a hold FSM that
//   produces long-press and auto-repeat pulses.
//
// Ports
//   clk            in   single clock, everything on the rising edge
//   rst            in   synchronous active-high reset
//   ch_en          in   [CH] per-channel enable; 0 holds the channel in reset
//   button_in      in   [CH] raw asynchronous key levels
//   button_out     out  [CH] debounced level (registered)
//   button_press   out  [CH] one-cycle pulse when the debounced level becomes PRESS_LVL
//   button_release out  [CH] one-cycle pulse when the debounced level leaves PRESS_LVL
//   button_long    out  [CH] one-cycle pulse once a press has been held LONG_CYCLES
//   button_repeat  out  [CH] pulse every REPEAT_CYCLES while held past the long press
//
// Handshake note: there is no valid/ready traffic here. Every output is a
// plain registered level or a single-cycle pulse; consumers sample them on
// the same clock with no back-pressure.
module key_debounce_bank #(
  parameter int unsigned CH            = 4,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned DEB_CYCLES    = 50000,
  parameter int unsigned LONG_CYCLES   = 100000000,
  parameter int unsigned REPEAT_CYCLES = 20000000,
  parameter logic        PRESS_LVL     = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] ch_en,
  input  logic [CH-1:0] button_in,
  output logic [CH-1:0] button_out,
  output logic [CH-1:0] button_press,
  output logic [CH-1:0] button_release,
  output logic [CH-1:0] button_long,
  output logic [CH-1:0] button_repeat
);

  typedef enum logic [1:0] {
    ST_RELEASED  = 2'd0,
    ST_HELD      = 2'd1,
    ST_LONG_HELD = 2'd2
  } hold_state_e;

  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES);
  // The hold counter starts at 0 on the cycle after the state is entered, so
  // the pulse fires when it shows N-1: the pulse edge is then exactly N edges
  // after the previous reference edge.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             out_q, out_d;
    logic             out_dly_q, out_dly_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    hold_state_e      state_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic             long_q;
    logic             repeat_q;
    logic             chan_clr;

    assign chan_clr = rst | ~ch_en[i];

    // Synchroniser, debounce counter and edge detect.
    always_comb begin
      s1_d = button_in[i];
      s2_d = s1_q;
      if (s1_q != s2_q) begin
        deb_cnt_d = '0;
      end else if (deb_cnt_q == DEB_MAX) begin
        deb_cnt_d = deb_cnt_q;
      end else begin
        deb_cnt_d = deb_cnt_q + CNT_W'(1);
      end
      out_d     = (deb_cnt_q == DEB_MAX) ? s2_q : out_q;
      out_dly_d = out_q;
      press_d   = (out_q != out_dly_q) && (out_q == PRESS_LVL);
      release_d = (out_q != out_dly_q) && (out_q != PRESS_LVL);
    end

    always_ff @(posedge clk) begin
      if (chan_clr) begin
        s1_q      <= ~PRESS_LVL;
        s2_q      <= ~PRESS_LVL;
        deb_cnt_q <= '0;
        out_q     <= ~PRESS_LVL;
        out_dly_q <= ~PRESS_LVL;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        s1_q      <= s1_d;
        s2_q      <= s2_d;
        deb_cnt_q <= deb_cnt_d;
        out_q     <= out_d;
        out_dly_q <= out_dly_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // Hold FSM. A released debounced level is checked before any pulse
    // condition, so release always wins over a long/repeat due that cycle.
    always_ff @(posedge clk) begin
      if (chan_clr) begin
        state_q    <= ST_RELEASED;
        hold_cnt_q <= '0;
        long_q     <= 1'b0;
        repeat_q   <= 1'b0;
      end else begin
        long_q   <= 1'b0;
        repeat_q <= 1'b0;
        case (state_q)
          ST_RELEASED: begin
            if (out_q == PRESS_LVL) begin
              state_q    <= ST_HELD;
              hold_cnt_q <= '0;
            end
          end
          ST_HELD: begin
            if (out_q != PRESS_LVL) begin
              state_q    <= ST_RELEASED;
              hold_cnt_q <= '0;
            end else if (hold_cnt_q == LONG_LAST) begin
              long_q     <= 1'b1;
              state_q    <= ST_LONG_HELD;
              hold_cnt_q <= '0;
            end else begin
              hold_cnt_q <= hold_cnt_q + CNT_W'(1);
            end
          end
          ST_LONG_HELD: begin
            if (out_q != PRESS_LVL) begin
              state_q    <= ST_RELEASED;
              hold_cnt_q <= '0;
            end else if (hold_cnt_q == REP_LAST) begin
              // Wrap to 0 on the pulse itself so the period never drifts.
              repeat_q   <= 1'b1;
              hold_cnt_q <= '0;
            end else begin
              hold_cnt_q <= hold_cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q    <= ST_RELEASED;
            hold_cnt_q <= '0;
          end
        endcase
      end
    end

    assign button_out[i]     = out_q;
    assign button_press[i]   = press_q;
    assign button_release[i] = release_q;
    assign button_long[i]    = long_q;
    assign button_repeat[i]  = repeat_q;
  end

endmodule

// File: doc/key_debounce_bank.md
KEY_DEBOUNCE_BANK -- requirements
Module: key_debounce_bank

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent key channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 32: width of every per-channel counter.
REQ-003 SHALL have parameter DEB_CYCLES, default 50000: stable-input cycles required before the output follows (0.5 ms at 100 MHz); 1..2^CNT_W-1.
REQ-004 SHALL have parameter LONG_CYCLES, default 100000000: pressed cycles before the long-press pulse (1 s at 100 MHz); 1..2^CNT_W-1.
REQ-005 SHALL have parameter REPEAT_CYCLES, default 20000000: auto-repeat period after long press; 1..2^CNT_W-1.
REQ-006 SHALL have parameter PRESS_LVL, default 1'b0: input level meaning "pressed" (active-low keys).
REQ-007 clk  input  1  single clock; all logic on its rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 ch_en  input  CH  per-channel enable.
REQ-010 button_in  input  CH  raw asynchronous key levels.
REQ-011 button_out  output  CH  debounced level, registered.
REQ-012 button_press  output  CH  1-cycle pulse: debounced level entered PRESS_LVL.
REQ-013 button_release  output  CH  1-cycle pulse: debounced level left PRESS_LVL.
REQ-014 button_long  output  CH  1-cycle pulse: press held LONG_CYCLES.
REQ-015 button_repeat  output  CH  1-cycle pulse train while held beyond long press.

Function
REQ-016 Each channel SHALL be independent; the behaviour below applies per bit i.
REQ-017 Input SHALL pass a 2-flop synchronizer (s1<=button_in, s2<=s1) before any other use.
REQ-018 Debounce counter SHALL clear to 0 on any cycle with s1!=s2, otherwise increment, saturating at DEB_CYCLES.
REQ-019 button_out SHALL load s2 on each cycle the debounce counter equals DEB_CYCLES, else hold.
REQ-020 Latency: input change sampled into s1 at edge k, held stable -> button_out changes at edge k+DEB_CYCLES+2.
REQ-021 Glitch shorter than DEB_CYCLES+1 cycles after synchronisation SHALL NOT change button_out.
REQ-022 button_press/button_release SHALL assert for exactly one cycle, at the edge after button_out changes (registered compare of button_out and its 1-cycle delayed copy).
REQ-023 Hold FSM states: RELEASED, HELD, LONG_HELD; counter hold_cnt (CNT_W bits).
REQ-024 RELEASED -> HELD when button_out==PRESS_LVL; hold_cnt cleared on entry.
REQ-025 HELD: button_long SHALL pulse exactly LONG_CYCLES+1 cycles after button_out reaches PRESS_LVL; then -> LONG_HELD, hold_cnt cleared.
REQ-026 LONG_HELD: button_repeat SHALL pulse every REPEAT_CYCLES cycles, first one REPEAT_CYCLES cycles after button_long; counter wraps to 0 on each pulse, no drift.
REQ-027 HELD or LONG_HELD -> RELEASED on the cycle button_out!=PRESS_LVL; release wins: no long/repeat pulse that cycle or later.
REQ-028 ch_en[i]=0 SHALL force the channel to its reset state each cycle (synchronizer, counters, FSM, outputs) and suppress all pulses; re-enable SHALL NOT produce a press/release pulse unless the debounced level later changes.
REQ-029 At most one of press/release/long/repeat SHALL be high per channel per cycle; press and long never coincide (LONG_CYCLES>=1).
REQ-030 Counters SHALL never overflow; compare values are parameters cast to CNT_W.

Reset
REQ-031 On rst=1 at a clock edge: s1, s2, button_out = ~PRESS_LVL; delayed copy = ~PRESS_LVL; all counters 0; FSM RELEASED; all pulse outputs 0.
REQ-032 Reset asserted mid-press SHALL abort the press with no release pulse; the first cycle after reset SHALL produce no pulse on any channel.
REQ-033 A key already held through reset SHALL produce a normal press pulse once debounced (DEB_CYCLES+2 cycles after reset release, pulse one cycle later).

Verification (CH=2, DEB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, PRESS_LVL=0)
REQ-034 ch0 held 0 from edge 10 -> button_out[0] 0 at edge 16, button_press[0] high only at edge 17; ch1 unchanged.
REQ-035 ch0 bouncing 0/1 every 3 cycles for 30 cycles, then 1 -> button_out[0] stays 1, no pulses.
REQ-036 ch0 pressed 60 cycles after debounce -> button_long once 21 cycles after button_out falls, button_repeat at +8, +16, +24 ...; release -> button_release once, no further repeats.
REQ-037 Both channels pressed on the same edge, ch1 released at long-press cycle -> ch0 gets button_long, ch1 gets only release.
REQ-038 rst pulse mid-LONG_HELD with key still held -> outputs return to reset values, no release pulse, new press pulse at edge 7 after reset release; ch_en[0]=0 for 50 cycles -> zero pulses on ch0.
